axum_bus_arb: RTL and testbench
===============================

# axum_bus_arb

Parametrised multi-host, multi-device data-bus interconnect for the axum SoC. It connects NrHosts ibex-style request/grant/rvalid hosts to NrDevices memory-mapped devices through a base/mask address decoder. It adds three things: round-robin arbitration between hosts, an internally generated error response for unmapped addresses, and a per-transaction response timeout. It sits between the core data port (plus future DMA or debug hosts) and the RAM, GPIO, timer and UART devices.

## Interface
- NrHosts, 2, number of host ports (≥1)
- NrDevices, 4, number of device ports (≥1)
- DataWidth, 32, data width in bits
- AddressWidth, 32, address width in bits
- TimeoutCycles, 255, maximum wait cycles for device rvalid; 0 disables the timeout

- clk_i  input  1  single clock, all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- host_req_i[NrHosts]  input  1  host request
- host_gnt_o[NrHosts]  output  1  host grant
- host_addr_i[NrHosts]  input  AddressWidth  byte address
- host_we_i[NrHosts]  input  1  write enable
- host_be_i[NrHosts]  input  DataWidth/8  byte enables
- host_wdata_i[NrHosts]  input  DataWidth  write data
- host_rvalid_o[NrHosts]  output  1  response valid
- host_rdata_o[NrHosts]  output  DataWidth  read data
- host_err_o[NrHosts]  output  1  response error, qualified by rvalid
- device_req_o[NrDevices]  output  1  device request
- device_addr_o / device_we_o / device_be_o / device_wdata_o [NrDevices]  output  as host  forwarded from the granted host
- device_rvalid_i[NrDevices]  input  1  device response valid
- device_rdata_i[NrDevices]  input  DataWidth  device read data
- device_err_i[NrDevices]  input  1  device error
- cfg_device_addr_base[NrDevices]  input  AddressWidth  decode base
- cfg_device_addr_mask[NrDevices]  input  AddressWidth  decode mask; device d matches when (addr & mask) == base

## Operation
- The block has two states, IDLE and WAIT, and supports one outstanding transaction at a time.
- In IDLE with any host_req_i high:
  - Grant exactly one host, chosen round-robin. The search starts at host (last_granted+1) mod NrHosts. last_granted resets to NrHosts-1, so host 0 wins first.
  - host_gnt_o is combinational, in the same cycle as req.
  - Decode the granted address. With multiple matches, the lowest device index wins.
  - On a match, assert device_req_o[d] in the same cycle and forward addr/we/be/wdata.
  - Register the owning host, the device, and the miss flag. Go to WAIT and update last_granted.
- On decode miss:
  - Assert no device_req_o; go to WAIT with the miss flag set.
  - In the next cycle drive host_rvalid_o=1, host_err_o=1, host_rdata_o=0 to the owner, then return to IDLE.
- In WAIT (hit):
  - When device_rvalid_i[d] is high, forward rdata/err combinationally to the owner's rvalid/rdata/err in that cycle, then return to IDLE.
  - rvalid from any other device is ignored.
- Timeout:
  - A counter of width $clog2(TimeoutCycles+1) clears on grant and increments each WAIT cycle without rvalid.
  - When it reaches TimeoutCycles, drive owner rvalid=1, err=1, rdata=0 and return to IDLE.
  - A later stale device rvalid is ignored.
  - If rvalid arrives in the same cycle the counter reaches TimeoutCycles, the device response wins (err from the device).
- Outputs for non-granted hosts and non-selected devices are 0. device_addr/we/be/wdata are 0 when not requested.
- No grant is issued while in WAIT; host requests must be held until granted.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, last_granted=NrHosts-1, counter 0.
  - All host_gnt_o, host_rvalid_o, host_err_o, device_req_o = 0; host_rdata_o = 0.
- Grant latency: 0 cycles from req in IDLE.
- Minimum response: 1 cycle after grant (single-cycle device or decode miss).
- Next grant: earliest in the cycle after rvalid, giving a throughput of 1 transaction per 2 cycles with 1-cycle devices.
- Timeout response: TimeoutCycles+1 cycles after grant, when no device rvalid arrives.
- Reset mid-WAIT: the transaction is dropped and no rvalid is issued to the host.

## Test plan
- Single host, RAM at 0x100000 / mask ~0x1FFF: read 0x100004 → gnt same cycle, device_req[0]=1, device responds rdata 0xDEADBEEF next cycle → host_rvalid=1, rdata 0xDEADBEEF, err=0.
- Two hosts requesting continuously → grants alternate H0, H1, H0, H1; no host is granted twice in a row while the other waits.
- Read 0x50000 (unmapped) → no device_req, next cycle rvalid=1, err=1, rdata=0.
- TimeoutCycles=4, device never responds → rvalid=1, err=1 exactly 5 cycles after grant. A device rvalid 2 cycles later is ignored, and the next request is granted normally.
- Device rvalid in the same cycle as the counter hits TimeoutCycles → device rdata returned, err=0.
- Assert rst_i during WAIT → all outputs 0 immediately; after release the next grant goes to host 0.

Source files
------------

// File: rtl/axum_bus_arb.sv
// axum_bus_arb: multi-host / multi-device data-bus interconnect.
// Round-robin host arbitration, base/mask decode with an internal error
// response for unmapped addresses, and a per-transaction response timeout.
// One transaction is outstanding at a time.

// Per-device address match: one instance per device port.
module axum_bus_arb_dec_lane #(
  parameter int unsigned AddressWidth = 32
) (
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [AddressWidth-1:0] base_i,
  input  logic [AddressWidth-1:0] mask_i,
  output logic                    match_o
);
  assign match_o = ((addr_i & mask_i) == base_i);
endmodule

module axum_bus_arb #(
  parameter int unsigned NrHosts       = 2,
  parameter int unsigned NrDevices     = 4,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NrHosts-1:0]                        host_req_i,
  output logic [NrHosts-1:0]                        host_gnt_o,
  input  logic [NrHosts-1:0][AddressWidth-1:0]      host_addr_i,
  input  logic [NrHosts-1:0]                        host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]       host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]         host_wdata_i,
  output logic [NrHosts-1:0]                        host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]         host_rdata_o,
  output logic [NrHosts-1:0]                        host_err_o,
  output logic [NrDevices-1:0]                      device_req_o,
  output logic [NrDevices-1:0][AddressWidth-1:0]    device_addr_o,
  output logic [NrDevices-1:0]                      device_we_o,
  output logic [NrDevices-1:0][DataWidth/8-1:0]     device_be_o,
  output logic [NrDevices-1:0][DataWidth-1:0]       device_wdata_o,
  input  logic [NrDevices-1:0]                      device_rvalid_i,
  input  logic [NrDevices-1:0][DataWidth-1:0]       device_rdata_i,
  input  logic [NrDevices-1:0]                      device_err_i,
  input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_base,
  input  logic [NrDevices-1:0][AddressWidth-1:0]    cfg_device_addr_mask
);
  localparam int unsigned HW   = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DVW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  // Keep the counter at least one bit wide so TimeoutCycles=0 still elaborates.
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] TO_CNT = CntW'(TimeoutCycles);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   owner_q, owner_d, last_q, last_d;
  logic [DVW-1:0]  dev_q, dev_d;
  logic            miss_q, miss_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            any_req;
  logic [HW-1:0]   sel;
  logic [NrDevices-1:0] match;
  logic            hit;
  logic [DVW-1:0]  dev_sel;

  // Round-robin pick: first requester at or after last_granted+1.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    for (int i = 0; i < NrHosts; i++) begin
      int idx;
      idx = (int'(last_q) + 1 + i) % NrHosts;
      if (!any_req && host_req_i[HW'(idx)]) begin
        any_req = 1'b1;
        sel     = HW'(idx);
      end
    end
  end

  // Decode the candidate host's address against every device window.
  for (genvar d = 0; d < NrDevices; d++) begin : g_dec
    axum_bus_arb_dec_lane #(.AddressWidth(AddressWidth)) u_lane (
      .addr_i  (host_addr_i[sel]),
      .base_i  (cfg_device_addr_base[d]),
      .mask_i  (cfg_device_addr_mask[d]),
      .match_o (match[d])
    );
  end

  // Priority on overlapping windows: lowest device index wins.
  always_comb begin
    hit     = 1'b0;
    dev_sel = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if (match[d]) begin
        hit     = 1'b1;
        dev_sel = DVW'(d);
      end
    end
  end

  // Next-state and outputs; everything is forced low while reset is held.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    dev_d          = dev_q;
    miss_d         = miss_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    host_gnt_o     = '0;
    host_rvalid_o  = '0;
    host_rdata_o   = '0;
    host_err_o     = '0;
    device_req_o   = '0;
    device_addr_o  = '0;
    device_we_o    = '0;
    device_be_o    = '0;
    device_wdata_o = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            host_gnt_o[sel] = 1'b1;
            if (hit) begin
              device_req_o[dev_sel]   = 1'b1;
              device_addr_o[dev_sel]  = host_addr_i[sel];
              device_we_o[dev_sel]    = host_we_i[sel];
              device_be_o[dev_sel]    = host_be_i[sel];
              device_wdata_o[dev_sel] = host_wdata_i[sel];
            end
            owner_d = sel;
            dev_d   = dev_sel;
            miss_d  = !hit;
            last_d  = sel;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (miss_q) begin
            host_rvalid_o[owner_q] = 1'b1;
            host_err_o[owner_q]    = 1'b1;
            state_d                = IDLE;
          end else if (device_rvalid_i[dev_q]) begin
            // Device response takes priority over a coincident timeout.
            host_rvalid_o[owner_q] = 1'b1;
            host_rdata_o[owner_q]  = device_rdata_i[dev_q];
            host_err_o[owner_q]    = device_err_i[dev_q];
            state_d                = IDLE;
          end else if (TimeoutCycles != 0 && cnt_q == TO_CNT) begin
            host_rvalid_o[owner_q] = 1'b1;
            host_err_o[owner_q]    = 1'b1;
            state_d                = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; last_granted resets so host 0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      dev_q   <= '0;
      miss_q  <= 1'b0;
      last_q  <= HW'(NrHosts - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dev_q   <= dev_d;
      miss_q  <= miss_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axum_bus_arb.sv
// Directed bench for axum_bus_arb: 2 hosts, 4 devices, timeout of 4 cycles.
module tb_axum_bus_arb;
  localparam int NH = 2, ND = 4, DW = 32, AW = 32, TO = 4;

  logic clk = 1'b0, rst;
  logic [NH-1:0]              host_req, gnt, host_we, rvalid, herr;
  logic [NH-1:0][AW-1:0]      host_addr;
  logic [NH-1:0][DW/8-1:0]    host_be;
  logic [NH-1:0][DW-1:0]      host_wdata, rdata;
  logic [ND-1:0]              dreq, dwe, drvalid, derr;
  logic [ND-1:0][AW-1:0]      daddr, base, mask;
  logic [ND-1:0][DW/8-1:0]    dbe;
  logic [ND-1:0][DW-1:0]      dwdata, drdata;

  int n_chk = 0, n_err = 0;

  axum_bus_arb #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW),
                 .AddressWidth(AW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(rvalid), .host_rdata_o(rdata), .host_err_o(herr),
    .device_req_o(dreq), .device_addr_o(daddr), .device_we_o(dwe),
    .device_be_o(dbe), .device_wdata_o(dwdata),
    .device_rvalid_i(drvalid), .device_rdata_i(drdata), .device_err_i(derr),
    .cfg_device_addr_base(base), .cfg_device_addr_mask(mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr_in();
    host_req = '0; host_we = '0; host_be = '0; host_wdata = '0; host_addr = '0;
    drvalid = '0; derr = '0; drdata = '0;
  endtask

  initial begin
    logic [1:0] eg;
    int eh;
    // RAM, GPIO, an overlapping window over RAM, UART
    base[0] = 32'h0010_0000; mask[0] = ~32'h1FFF;
    base[1] = 32'h0020_0000; mask[1] = 32'hFFFF_F000;
    base[2] = 32'h0010_0000; mask[2] = 32'hFFFF_0000;
    base[3] = 32'h0040_0000; mask[3] = 32'hFFFF_F000;
    clr_in();
    rst = 1'b1;
    host_req = 2'b11; host_addr[0] = 32'h0010_0004;
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_dreq", dreq, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    clr_in();
    cyc(); rst = 1'b0;

    // single read to RAM
    cyc(); host_req = 2'b01; host_addr[0] = 32'h0010_0004; #1;
    chk("rd_gnt", gnt, 2'b01);
    chk("rd_dreq", dreq, 4'b0001);
    chk("rd_daddr0", daddr[0], 32'h0010_0004);
    chk("rd_daddr3", daddr[3], 0);
    cyc(); host_req = '0; drvalid = 4'b0001; drdata[0] = 32'hDEAD_BEEF; #1;
    chk("rd_rvalid", rvalid, 2'b01);
    chk("rd_rdata", rdata[0], 32'hDEAD_BEEF);
    chk("rd_err", herr, 0);
    cyc(); clr_in();

    // both hosts request continuously: alternate starting with host 1
    for (int i = 0; i < 4; i++) begin
      eh = (i % 2 == 0) ? 1 : 0;
      eg = (eh == 1) ? 2'b10 : 2'b01;
      cyc();
      host_req = 2'b11; host_addr[0] = 32'h0010_0010; host_addr[1] = 32'h0020_0020;
      drvalid = '0; #1;
      chk("rr_gnt", gnt, eg);
      chk("rr_dreq", dreq, (eh == 1) ? 4'b0010 : 4'b0001);
      cyc();
      drvalid = (eh == 1) ? 4'b0010 : 4'b0001;
      drdata[0] = 32'h1000 + i; drdata[1] = 32'h1000 + i; #1;
      chk("rr_wait_gnt", gnt, 0);
      chk("rr_rvalid", rvalid, eg);
      chk("rr_rdata", rdata[eh], 32'h1000 + i);
    end
    cyc(); clr_in();

    // unmapped address from host 1
    cyc(); host_req = 2'b10; host_addr[1] = 32'h0005_0000; #1;
    chk("miss_gnt", gnt, 2'b10);
    chk("miss_dreq", dreq, 0);
    cyc(); host_req = '0; drvalid = 4'b0001; drdata[0] = 32'h5555_AAAA; #1;
    chk("miss_rvalid", rvalid, 2'b10);
    chk("miss_err", herr, 2'b10);
    chk("miss_rdata", rdata[1], 0);
    cyc(); clr_in();

    // timeout: UART never answers
    cyc(); host_req = 2'b01; host_addr[0] = 32'h0040_0008; #1;
    chk("to_gnt", gnt, 2'b01);
    chk("to_dreq", dreq, 4'b1000);
    for (int k = 1; k <= 4; k++) begin
      cyc(); host_req = '0; drvalid = (k == 2) ? 4'b0001 : 4'b0000; #1;
      chk("to_pending", rvalid, 0);
    end
    cyc(); drvalid = '0; #1;
    chk("to_rvalid", rvalid, 2'b01);
    chk("to_err", herr, 2'b01);
    chk("to_rdata", rdata[0], 0);
    cyc(); clr_in();
    // stale UART rvalid alongside a fresh request
    cyc(); drvalid = 4'b1000; drdata[3] = 32'hBAD0_BAD0;
    host_req = 2'b01; host_addr[0] = 32'h0010_0004; #1;
    chk("stale_rvalid", rvalid, 0);
    chk("stale_gnt", gnt, 2'b01);
    cyc(); host_req = '0; drvalid = 4'b0001; drdata[0] = 32'h1234_5678; #1;
    chk("after_to_rdata", rdata[0], 32'h1234_5678);
    cyc(); clr_in();

    // device answers on the timeout cycle: device wins
    cyc(); host_req = 2'b10; host_addr[1] = 32'h0020_0000; #1;
    chk("race_gnt", gnt, 2'b10);
    for (int k = 1; k <= 4; k++) begin
      cyc(); host_req = '0; #1;
    end
    chk("race_pending", rvalid, 0);
    cyc(); drvalid = 4'b0010; drdata[1] = 32'hCAFE_F00D; #1;
    chk("race_rvalid", rvalid, 2'b10);
    chk("race_rdata", rdata[1], 32'hCAFE_F00D);
    chk("race_err", herr, 0);
    cyc(); clr_in();

    // overlap window beyond RAM -> device 2; write forwarding, device error
    cyc(); host_req = 2'b01; host_addr[0] = 32'h0010_A000; host_we = 2'b01;
    host_be[0] = 4'b0110; host_wdata[0] = 32'hA5A5_0101; #1;
    chk("ovl_dreq", dreq, 4'b0100);
    chk("ovl_we", dwe, 4'b0100);
    chk("ovl_be", dbe[2], 4'b0110);
    chk("ovl_wdata", dwdata[2], 32'hA5A5_0101);
    cyc(); host_req = '0; host_we = '0; drvalid = 4'b0100; derr = 4'b0100; #1;
    chk("ovl_err", herr, 2'b01);
    cyc(); clr_in();

    // reset while waiting: outputs drop, host 0 wins after release
    cyc(); host_req = 2'b01; host_addr[0] = 32'h0010_0000; #1;
    chk("rstw_gnt", gnt, 2'b01);
    cyc(); rst = 1'b1; host_req = 2'b11; drvalid = 4'b0001; drdata[0] = 32'h7777_7777; #1;
    chk("rstw_rvalid", rvalid, 0);
    chk("rstw_gnt0", gnt, 0);
    chk("rstw_dreq", dreq, 0);
    cyc(); rst = 1'b0; drvalid = '0; host_addr[1] = 32'h0020_0000; #1;
    chk("rstw_regnt", gnt, 2'b01);
    cyc(); clr_in();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
